// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a word-wide data memory (RV32I LB/LH/LW/LBU/LHU/SB/SH/SW).
// Optional feature: `define MISALIGNED_SPLIT_EN to split misaligned accesses across two words.
module lsu_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  stall,
    output logic                  misaligned,
    output logic                  dmem_we,
    output logic [ADDR_WIDTH-3:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);
    localparam int WORD_W = ADDR_WIDTH - 2;

`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {IDLE, RMW_WR, SPL_WR0, SPL_RD1, SPL_WR1} state_t;
`else
    typedef enum logic [2:0] {IDLE, RMW_WR} state_t;
`endif

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic signed [7:0]  sb;
        logic signed [15:0] sh16;
        logic [31:0]        r;
        sb   = raw[7:0];
        sh16 = raw[15:0];
        case (f3)
            3'b000:  r = 32'(sb);
            3'b001:  r = 32'(sh16);
            3'b100:  r = {24'd0, raw[7:0]};
            3'b101:  r = {16'd0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

    function automatic logic [3:0] size_mask(input logic [1:0] sz);
        return (sz == 2'b00) ? 4'b0001 : (sz == 2'b01) ? 4'b0011 : 4'b1111;
    endfunction

    state_t            state, state_n;
    logic [WORD_W-1:0] waddr, waddr_n;
    logic [31:0]       mbuf, mbuf_n;
`ifdef MISALIGNED_SPLIT_EN
    logic [31:0]       lo_word, lo_word_n, sdata_l, sdata_l_n;
    logic [1:0]        off_l, off_l_n;
    logic [2:0]        f3_l, f3_l_n;
    logic              is_st_l, is_st_l_n;
    logic [4:0]        sh_l;
`endif

    logic [1:0] off;
    logic [4:0] sh;
    logic [3:0] m4;
    logic       ld_ok, st_ok, acc, mis_al;

    always_comb begin
        off    = addr[1:0];
        sh     = {off, 3'b000};
        m4     = size_mask(funct3[1:0]);
        ld_ok  = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_ok  = funct3 inside {3'b000, 3'b001, 3'b010};
        // a store wins over a load when both are flagged
        acc    = req_valid && (req_write ? st_ok : (req_read && ld_ok));
        mis_al = (funct3[1:0] == 2'b10 && off != 2'b00) || (funct3[1:0] == 2'b01 && off[0]);
    end

    always_comb begin
        state_n    = state;
        waddr_n    = waddr;
        mbuf_n     = mbuf;
        stall      = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = addr[ADDR_WIDTH-1:2];
        dmem_wdata = store_data;
        load_data  = '0;
        load_valid = 1'b0;
        misaligned = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
        lo_word_n  = lo_word;
        sdata_l_n  = sdata_l;
        off_l_n    = off_l;
        f3_l_n     = f3_l;
        is_st_l_n  = is_st_l;
        sh_l       = {off_l, 3'b000};
`endif
        case (state)
            IDLE: begin
                if (acc) begin
                    if (mis_al) begin
`ifdef MISALIGNED_SPLIT_EN
                        // this cycle is the first read of word W
                        stall     = 1'b1;
                        waddr_n   = addr[ADDR_WIDTH-1:2];
                        off_l_n   = off;
                        f3_l_n    = funct3;
                        sdata_l_n = store_data;
                        is_st_l_n = req_write;
                        if (req_write) begin
                            mbuf_n  = merge(dmem_rdata, store_data << sh, m4 << off);
                            state_n = SPL_WR0;
                        end else begin
                            lo_word_n = dmem_rdata;
                            state_n   = SPL_RD1;
                        end
`else
                        misaligned = 1'b1;
`endif
                    end else if (req_write) begin
                        if (funct3[1:0] == 2'b10) begin
                            dmem_we = 1'b1;
                        end else begin
                            stall   = 1'b1;
                            waddr_n = addr[ADDR_WIDTH-1:2];
                            mbuf_n  = merge(dmem_rdata, store_data << sh, m4 << off);
                            state_n = RMW_WR;
                        end
                    end else begin
                        load_valid = 1'b1;
                        load_data  = extend(dmem_rdata >> sh, funct3);
                    end
                end
            end
            RMW_WR: begin
                dmem_we    = 1'b1;
                dmem_addr  = waddr;
                dmem_wdata = mbuf;
                state_n    = IDLE;
            end
`ifdef MISALIGNED_SPLIT_EN
            SPL_WR0: begin
                stall      = 1'b1;
                dmem_we    = 1'b1;
                dmem_addr  = waddr;
                dmem_wdata = mbuf;
                state_n    = SPL_RD1;
            end
            SPL_RD1: begin
                dmem_addr = waddr + 1'b1;
                if (is_st_l) begin
                    stall   = 1'b1;
                    mbuf_n  = merge(dmem_rdata, sdata_l >> (6'd32 - {1'b0, sh_l}),
                                    size_mask(f3_l[1:0]) >> (3'd4 - {1'b0, off_l}));
                    state_n = SPL_WR1;
                end else begin
                    load_valid = 1'b1;
                    load_data  = extend((lo_word >> sh_l) | (dmem_rdata << (6'd32 - {1'b0, sh_l})),
                                        f3_l);
                    state_n    = IDLE;
                end
            end
            SPL_WR1: begin
                dmem_we    = 1'b1;
                dmem_addr  = waddr + 1'b1;
                dmem_wdata = mbuf;
                state_n    = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            waddr   <= '0;
            mbuf    <= '0;
`ifdef MISALIGNED_SPLIT_EN
            lo_word <= '0;
            sdata_l <= '0;
            off_l   <= '0;
            f3_l    <= '0;
            is_st_l <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            waddr   <= waddr_n;
            mbuf    <= mbuf_n;
`ifdef MISALIGNED_SPLIT_EN
            lo_word <= lo_word_n;
            sdata_l <= sdata_l_n;
            off_l   <= off_l_n;
            f3_l    <= f3_l_n;
            is_st_l <= is_st_l_n;
`endif
        end
    end

endmodule
